// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//
// Command buffer and issue sequencer in front of sequential_alu.
// Commands {op, a, b} are queued in a DEPTH-entry FIFO and issued one at a
// time. Operands and a one-hot op strobe are held stable until the ALU
// reports o_accept. The captured result is then offered on a valid/ready
// result port. A divide by zero is answered locally (q=0, ovf=1) and the
// ALU never sees it.
//
// Ports
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready         command handshake (ready = !full)
//   i_cmd_op, i_cmd_a, i_cmd_b        op (0 add, 1 sub, 2 mul, 3 div), operands
//   o_alu_a, o_alu_b                  registered operands to the ALU
//   o_alu_add/sub/mul/div             registered one-hot op strobes
//   i_alu_q, i_alu_ovf, i_alu_accept  ALU result, overflow, result valid
//   o_res_valid / i_res_ready         result handshake
//   o_res_q, o_res_ovf, o_res_op      result value, overflow/div0, op code
//   o_level                           FIFO occupancy 0..DEPTH
//   o_busy                            FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [1:0]                 i_cmd_op,
    input  logic [DATA_WIDTH-1:0]      i_cmd_a,
    input  logic [DATA_WIDTH-1:0]      i_cmd_b,
    output logic [DATA_WIDTH-1:0]      o_alu_a,
    output logic [DATA_WIDTH-1:0]      o_alu_b,
    output logic                       o_alu_add,
    output logic                       o_alu_sub,
    output logic                       o_alu_mul,
    output logic                       o_alu_div,
    input  logic [DATA_WIDTH-1:0]      i_alu_q,
    input  logic                       i_alu_ovf,
    input  logic                       i_alu_accept,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [DATA_WIDTH-1:0]      o_res_q,
    output logic                       o_res_ovf,
    output logic [1:0]                 o_res_op,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;

    // FIFO storage and pointers
    logic [1:0]              op_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   a_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]   b_mem  [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;

    // Issue / result registers
    logic [DATA_WIDTH-1:0]   alu_a_reg, alu_b_reg;
    logic [3:0]              strobe_reg;        // {div, mul, sub, add}
    logic [DATA_WIDTH-1:0]   res_q_reg;
    logic                    res_ovf_reg;
    logic [1:0]              res_op_reg;

    logic                    full, empty, push, pop;
    logic [1:0]              head_op;
    logic [DATA_WIDTH-1:0]   head_a, head_b;
    logic                    head_div0;
    logic [3:0]              head_onehot;

    assign full  = (level_reg == LVL_W'(DEPTH));
    assign empty = (level_reg == '0);
    assign push  = i_cmd_valid && !full;
    // Popping only from IDLE keeps a single command in flight.
    assign pop   = (state_reg == IDLE) && !empty;

    // The head is read combinationally so the pop decision (including the
    // divide-by-zero trap) is made in the same cycle the entry is visible.
    assign head_op   = op_mem[rd_ptr_reg];
    assign head_a    = a_mem[rd_ptr_reg];
    assign head_b    = b_mem[rd_ptr_reg];
    assign head_div0 = (head_op == 2'd3) && (head_b == '0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign head_onehot[gi] = (head_op == 2'(gi));
        end
    endgenerate

    // FIFO storage carries no reset; validity is tracked by level_reg.
    always_ff @(posedge i_clk) begin
        if (push) begin
            op_mem[wr_ptr_reg] <= i_cmd_op;
            a_mem[wr_ptr_reg]  <= i_cmd_a;
            b_mem[wr_ptr_reg]  <= i_cmd_b;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop)          state_next = head_div0 ? RESP : ISSUE;
            ISSUE:   if (i_alu_accept) state_next = RESP;
            RESP:    if (i_res_ready)  state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Issue and result datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            strobe_reg  <= '0;
            res_q_reg   <= '0;
            res_ovf_reg <= 1'b0;
            res_op_reg  <= '0;
        end else begin
            if (pop) begin
                res_op_reg <= head_op;
                if (head_div0) begin
                    // Trapped locally: answer without touching the ALU.
                    res_q_reg   <= '0;
                    res_ovf_reg <= 1'b1;
                end else begin
                    alu_a_reg  <= head_a;
                    alu_b_reg  <= head_b;
                    strobe_reg <= head_onehot;
                end
            end
            if ((state_reg == ISSUE) && i_alu_accept) begin
                res_q_reg   <= i_alu_q;
                res_ovf_reg <= i_alu_ovf;
                strobe_reg  <= '0;
            end
        end
    end

    assign o_cmd_ready = !full;
    assign o_alu_a     = alu_a_reg;
    assign o_alu_b     = alu_b_reg;
    assign o_alu_add   = strobe_reg[0];
    assign o_alu_sub   = strobe_reg[1];
    assign o_alu_mul   = strobe_reg[2];
    assign o_alu_div   = strobe_reg[3];
    assign o_res_valid = (state_reg == RESP);
    assign o_res_q     = res_q_reg;
    assign o_res_ovf   = res_ovf_reg;
    assign o_res_op    = res_op_reg;
    assign o_level     = level_reg;
    assign o_busy      = (state_reg != IDLE) || !empty;

endmodule
